// File: rtl/cc_random_mux.sv
// Galois-LFSR random source multiplexed with external channels, delivered
// through a single-entry valid/ack output register.
module cc_random_mux #(
  parameter int                        RANDOM_WIDTH = 8,
  parameter int                        NCH          = 2,
  parameter int                        SELECT_WIDTH = 2,
  parameter logic [RANDOM_WIDTH-1:0]   SEED         = 8'h5A,
  parameter logic [RANDOM_WIDTH-1:0]   TAPS         = 8'hB8
) (
  input  logic                         CC_RANDOM_MUX_CLOCK_50,
  input  logic                         CC_RANDOM_MUX_RESET_InHigh,
  input  logic                         CC_RANDOM_MUX_enable_In,
  input  logic                         CC_RANDOM_MUX_seedLoad_In,
  input  logic [RANDOM_WIDTH-1:0]      CC_RANDOM_MUX_seed_InBUS,
  input  logic [SELECT_WIDTH-1:0]      CC_RANDOM_MUX_select_InBUS,
  input  logic [NCH*RANDOM_WIDTH-1:0]  CC_RANDOM_MUX_channel_InBUS,
  input  logic                         CC_RANDOM_MUX_request_In,
  input  logic                         CC_RANDOM_MUX_ack_In,
  output logic [RANDOM_WIDTH-1:0]      CC_RANDOM_MUX_RANDOM_Out,
  output logic                         CC_RANDOM_MUX_valid_Out
);

  localparam int W = RANDOM_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  state_e         state_q;
  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [W-1:0]   rand_q;
  logic           valid_q;
  logic [W-1:0]   src_sel;
  logic           capture;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // A zero runtime seed would lock the LFSR, so fall back to SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (CC_RANDOM_MUX_seedLoad_In) begin
      lfsr_d = (CC_RANDOM_MUX_seed_InBUS == '0) ? SEED : CC_RANDOM_MUX_seed_InBUS;
    end else if (CC_RANDOM_MUX_enable_In) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge CC_RANDOM_MUX_CLOCK_50 or posedge CC_RANDOM_MUX_RESET_InHigh) begin
    if (CC_RANDOM_MUX_RESET_InHigh) lfsr_q <= SEED;
    else                            lfsr_q <= lfsr_d;
  end

  // Out-of-range selects resolve to the current output so a capture is a no-op on data.
  always_comb begin
    src_sel = rand_q;
    if (CC_RANDOM_MUX_select_InBUS == '0) src_sel = lfsr_q;
    for (int k = 0; k < NCH; k++) begin
      if (int'(CC_RANDOM_MUX_select_InBUS) == k + 1)
        src_sel = CC_RANDOM_MUX_channel_InBUS[k*W +: W];
    end
  end

  assign capture = CC_RANDOM_MUX_request_In &&
                   ((state_q == ST_IDLE) || CC_RANDOM_MUX_ack_In);

  always_ff @(posedge CC_RANDOM_MUX_CLOCK_50 or posedge CC_RANDOM_MUX_RESET_InHigh) begin
    if (CC_RANDOM_MUX_RESET_InHigh) begin
      state_q <= ST_IDLE;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            rand_q  <= src_sel;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (CC_RANDOM_MUX_ack_In) begin
            if (capture) begin
              rand_q <= src_sel;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign CC_RANDOM_MUX_RANDOM_Out = rand_q;
  assign CC_RANDOM_MUX_valid_Out  = valid_q;

endmodule
